// File: rtl/msk_tx_framer.sv
// MSK transmit framer: serialises preamble, sync word, length byte, payload and tail
// into symbols of SPS clocks each, with a one-byte prefetch holding register.
module msk_tx_framer #(
    parameter int unsigned SPS       = 20,
    parameter int unsigned PRE_BITS  = 32,
    parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
    parameter int unsigned TAIL_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       bit_out,
    output logic       sym_strobe,
    output logic       tx_active,
    output logic       done,
    output logic       underrun
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PRE  = 3'd1;
    localparam logic [2:0] SYNC = 3'd2;
    localparam logic [2:0] LEN  = 3'd3;
    localparam logic [2:0] DATA = 3'd4;
    localparam logic [2:0] TAIL = 3'd5;

    localparam logic [9:0]  SC_LAST   = 10'(SPS - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PRE_BITS - 1);
    localparam logic [15:0] TAIL_LAST = 16'(TAIL_BITS - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [9:0]  sc;
    logic [15:0] sym_idx;
    logic [7:0]  len_q;
    logic [7:0]  hold;
    logic        hold_full;
    logic [8:0]  fetched;
    logic [7:0]  shreg;

    logic        sym_end;
    logic        last_sym;
    logic        load;
    logic        starve;
    logic        hs;
    logic [4:0]  sync_idx;
    logic [2:0]  byte_bit;
    logic [12:0] last_byte;

    assign sym_end   = (state != IDLE) && (sc == SC_LAST);
    assign sync_idx  = 5'd31 - sym_idx[4:0];
    assign byte_bit  = 3'd7 - sym_idx[2:0];
    assign last_byte = {5'd0, len_q} - 13'd1;

    always_comb begin
        last_sym   = 1'b0;
        next_state = state;
        case (state)
            PRE: begin
                last_sym   = (sym_idx == PRE_LAST);
                next_state = SYNC;
            end
            SYNC: begin
                last_sym   = (sym_idx == 16'd31);
                next_state = LEN;
            end
            LEN: begin
                last_sym   = (sym_idx == 16'd7);
                next_state = (len_q == 8'd0) ? TAIL : DATA;
            end
            DATA: begin
                last_sym   = (sym_idx[2:0] == 3'd7) && (sym_idx[15:3] == last_byte);
                next_state = TAIL;
            end
            TAIL: begin
                last_sym   = (sym_idx == TAIL_LAST);
                next_state = IDLE;
            end
            default: begin
                last_sym   = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // A payload byte boundary is the end of LEN (non-empty payload) or the end of
    // any payload byte that is not the last one.
    assign load = sym_end &&
                  (((state == LEN) && last_sym && (len_q != 8'd0)) ||
                   ((state == DATA) && (sym_idx[2:0] == 3'd7) && !last_sym));
    assign starve = load && !hold_full;

    assign s_tready = ((state == LEN) || (state == DATA)) && !hold_full &&
                      (fetched < {1'b0, len_q});
    assign hs       = s_tvalid && s_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sc      <= '0;
            sym_idx <= '0;
            len_q   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state   <= PRE;
                sc      <= '0;
                sym_idx <= '0;
                len_q   <= len;
            end
        end else if (sym_end) begin
            sc <= '0;
            if (last_sym) begin
                state   <= next_state;
                sym_idx <= '0;
            end else begin
                sym_idx <= sym_idx + 16'd1;
            end
        end else begin
            sc <= sc + 10'd1;
        end
    end

    // A starved byte slot still counts as fetched so the frame length is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
            fetched   <= '0;
            shreg     <= '0;
            underrun  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                hold_full <= 1'b0;
                fetched   <= '0;
                underrun  <= 1'b0;
            end
        end else begin
            if (hs)
                hold <= s_tdata;
            if (load) begin
                hold_full <= hs;
                shreg     <= hold_full ? hold : 8'h00;
                if (!hold_full)
                    underrun <= 1'b1;
            end else if (hs) begin
                hold_full <= 1'b1;
            end
            fetched <= fetched + {8'd0, hs} + {8'd0, starve};
        end
    end

    always_comb begin
        bit_out = 1'b0;
        case (state)
            PRE:     bit_out = ~sym_idx[0];
            SYNC:    bit_out = SYNC_WORD[sync_idx];
            LEN:     bit_out = len_q[byte_bit];
            DATA:    bit_out = shreg[byte_bit];
            default: bit_out = 1'b0;
        endcase
    end

    assign sym_strobe = (state != IDLE) && (sc == 10'd0);
    assign tx_active  = (state != IDLE);
    assign done       = sym_end && (state == TAIL) && last_sym;

endmodule

// File: tb/tb_msk_tx_framer.sv
// Directed bench for msk_tx_framer: expected symbol bits are queued per frame and
// popped on every sym_strobe; frame timing, handshakes and flags are checked inline.
module tb_msk_tx_framer;

    localparam int SPS = 20;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       bit_out;
    logic       sym_strobe;
    logic       tx_active;
    logic       done;
    logic       underrun;

    msk_tx_framer #(
        .SPS(SPS),
        .PRE_BITS(32),
        .SYNC_WORD(32'h1ACF_FC1D),
        .TAIL_BITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .len(len),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .bit_out(bit_out),
        .sym_strobe(sym_strobe),
        .tx_active(tx_active),
        .done(done),
        .underrun(underrun)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_strobe = -1;
    int   done_cnt = 0;
    int   accepted = 0;
    bit   ready_seen = 0;
    logic cur_bit = 1'b0;
    bit   exp_q[$];

    logic [7:0] src_bytes [4];
    int   src_n = 0;
    int   src_idx = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic push_frame(input int n, input bit supply);
        logic [31:0] sw;
        sw = 32'h1ACF_FC1D;
        for (int i = 0; i < 32; i++) exp_q.push_back(i % 2 == 0);
        for (int i = 31; i >= 0; i--) exp_q.push_back(sw[i]);
        push_byte(8'(n));
        for (int i = 0; i < n; i++) push_byte(supply ? src_bytes[i] : 8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    endtask

    // Byte source: a handshake seen at the falling edge completes on the next rising edge.
    always begin
        bit take;
        @(negedge clk);
        take = s_tvalid && s_tready;
        if (s_tready) ready_seen = 1;
        @(posedge clk);
        #1;
        if (take) begin
            src_idx++;
            accepted++;
        end
        s_tvalid = (src_idx < src_n);
        s_tdata  = (src_idx < 4) ? src_bytes[src_idx] : 8'h00;
    end

    // Symbol monitor: pops one expected bit per strobe and checks spacing and hold.
    always begin
        @(posedge clk);
        #1;
        if (!tx_active) begin
            last_strobe = -1;
        end else if (sym_strobe) begin
            if (last_strobe >= 0) check("sym_gap", cyc - last_strobe, SPS);
            last_strobe = cyc;
            cur_bit = bit_out;
            if (exp_q.size() == 0) check("sym_extra", 1, 0);
            else check("sym_bit", bit_out, exp_q.pop_front());
        end else begin
            check("sym_hold", bit_out, cur_bit);
        end
        if (done) done_cnt++;
    end

    task automatic run_frame(input string tag, input int n, input bit supply, input int restart_at);
        int c0;
        int dcyc;
        int flen;
        bit seen;
        seen = 0;
        dcyc = 0;
        flen = (32 + 32 + 8 + 8 * n + 4) * SPS;
        src_idx = 0;
        src_n = supply ? n : 0;
        accepted = 0;
        ready_seen = 0;
        done_cnt = 0;
        push_frame(n, supply);
        start = 1'b1;
        len = 8'(n);
        c0 = cyc;
        tick();
        start = 1'b0;
        len = 8'hFF;
        check({tag, "_pre_entry"}, {31'd0, tx_active}, 1);
        for (int k = 1; k < 3000; k++) begin
            start = (k == restart_at);
            tick();
            if (done) begin
                seen = 1;
                dcyc = cyc;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, seen}, 1);
        check({tag, "_done_time"}, dcyc - c0, flen);
        tick();
        check({tag, "_idle_after"}, {31'd0, tx_active}, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_underrun"}, {31'd0, underrun}, {31'd0, (!supply && n > 0)});
        check({tag, "_accepted"}, accepted, supply ? n : 0);
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        start = 1'b0;
        len = 8'h00;
        s_tdata = 8'h00;
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) src_bytes[i] = 8'h00;
        tick();
        tick();
        check("reset_outputs", {26'd0, bit_out, sym_strobe, tx_active, done, underrun, s_tready}, 0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_outputs", {26'd0, bit_out, sym_strobe, tx_active, done, underrun, s_tready}, 0);

        src_bytes[0] = 8'hA5;
        run_frame("s1_len1", 1, 1, 0);

        run_frame("s2_len0", 0, 1, 0);
        check("s2_no_ready", {31'd0, ready_seen}, 0);

        run_frame("s3_starved", 3, 0, 0);

        src_bytes[0] = 8'h5C;
        src_bytes[1] = 8'hC3;
        run_frame("s4_restart", 2, 1, 700);

        // Abort mid-payload with an asynchronous reset between clock edges.
        src_bytes[0] = 8'h12;
        src_bytes[1] = 8'h34;
        src_idx = 0;
        src_n = 2;
        done_cnt = 0;
        push_frame(2, 1);
        start = 1'b1;
        len = 8'd2;
        c0 = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 1500; k++) tick();
        check("s5_in_frame", {31'd0, tx_active}, 1);
        #3;
        reset = 1'b1;
        #1;
        check("s5_async_zero", {26'd0, bit_out, sym_strobe, tx_active, done, underrun, s_tready}, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("s5_idle_after", {31'd0, tx_active}, 0);
        check("s5_no_done", done_cnt, 0);
        check("s5_cycles", cyc - c0, 1504);
        src_bytes[0] = 8'h3C;
        run_frame("s5_recover", 1, 1, 0);

        src_bytes[0] = 8'h00;
        src_bytes[1] = 8'hFF;
        src_bytes[2] = 8'h81;
        src_bytes[3] = 8'h7E;
        run_frame("s6_b2b", 4, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
